// File: rtl/mem_arb_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  // Owner tag carried alongside each in-flight memory read.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  // Activity state of the arbiter; used for observability and power gating.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Owner-tag shift register that follows each read through the memory latency.
// A flush cancels fetch tags still inside the pipe; the tail tag being
// delivered in the flush cycle is unaffected because it leaves at that edge.
module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic   clk,
  input  logic   rstn,
  input  logic   flush,
  input  owner_t push,
  output owner_t tail,
  output logic   pipe_empty
);

  owner_t stage_q [MEM_LATENCY];

  // Shift tags toward the tail, dropping fetch tags that are overtaken by a flush.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        stage_q[i] <= OWN_NONE;
      end
    end else begin
      stage_q[0] <= push;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        stage_q[i] <= (flush && (stage_q[i-1] == OWN_I)) ? OWN_NONE : stage_q[i-1];
      end
    end
  end

  // Report whether any read is still travelling through the pipe.
  always_comb begin
    pipe_empty = 1'b1;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      if (stage_q[i] != OWN_NONE) begin
        pipe_empty = 1'b0;
      end
    end
  end

  assign tail = stage_q[MEM_LATENCY-1];

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port synchronous memory between the fetch port and
// the load/store port. Data has priority, with a streak counter that forces a
// fetch grant after too many consecutive contended data grants.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MEM_LATENCY     = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_req,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  output logic                      i_ready,
  output logic                      i_rvalid,
  output logic [DATA_WIDTH-1:0]     i_rdata,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [ADDR_WIDTH-1:0]     d_addr,
  input  logic [DATA_WIDTH-1:0]     d_wdata,
  input  logic [DATA_WIDTH/8-1:0]   d_be,
  output logic                      d_ready,
  output logic                      d_rvalid,
  output logic [DATA_WIDTH-1:0]     d_rdata,
  input  logic                      flush,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_be,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      fetch_stall,
  output logic                      mem_stall
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam int BW = DATA_WIDTH / 8;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  logic [SW-1:0] streak_q;
  logic          d_win;
  logic          i_win;
  logic          grant;
  owner_t        push_tag;
  owner_t        tail_tag;
  logic          pipe_empty;
  arb_state_t    state_q;
  arb_state_t    state_d;

  // Pick the winner: data first, unless fetch has waited out a full streak.
  always_comb begin
    d_win = d_req && (!i_req || (streak_q != STREAK_MAX));
    i_win = i_req && !d_win;
  end

  assign grant       = i_win | d_win;
  assign d_ready     = d_win;
  assign i_ready     = i_win;
  assign fetch_stall = i_req & ~i_win;
  assign mem_stall   = d_req & ~d_win;

  // Count consecutive contended data grants; any fetch grant or idle fetch resets it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      streak_q <= '0;
    end else if (!i_req || i_win) begin
      streak_q <= '0;
    end else if (d_win && (streak_q != STREAK_MAX)) begin
      streak_q <= streak_q + 1'b1;
    end
  end

  // Route the winner onto the memory port and tag reads with their owner.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    push_tag  = OWN_NONE;
    if (d_win) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
      push_tag  = d_we ? OWN_NONE : OWN_D;
    end else if (i_win) begin
      mem_en    = 1'b1;
      mem_addr  = i_addr;
      mem_be    = {BW{1'b1}};
      push_tag  = OWN_I;
    end
  end

  rd_tag_pipe #(
    .MEM_LATENCY (MEM_LATENCY)
  ) u_rd_tag_pipe (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .push       (push_tag),
    .tail       (tail_tag),
    .pipe_empty (pipe_empty)
  );

  assign i_rvalid = (tail_tag == OWN_I);
  assign d_rvalid = (tail_tag == OWN_D);
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

  // Activity state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Track whether the port is issuing, draining outstanding reads, or quiet.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!grant) state_d = pipe_empty ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (grant)           state_d = ACTIVE;
        else if (pipe_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench: two arbiters (read latency 1 and 2) share the same
// requesters; a scoreboard per instance checks every read response.
module tb_unified_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_req, d_req, d_we, flush;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_be;

  logic        i_ready_a, i_rvalid_a, d_ready_a, d_rvalid_a, mem_en_a, mem_we_a;
  logic        fetch_stall_a, mem_stall_a;
  logic [31:0] i_rdata_a, d_rdata_a, mem_addr_a, mem_wdata_a;
  logic [3:0]  mem_be_a;
  logic        i_ready_b, i_rvalid_b, d_ready_b, d_rvalid_b, mem_en_b, mem_we_b;
  logic        fetch_stall_b, mem_stall_b;
  logic [31:0] i_rdata_b, d_rdata_b, mem_addr_b, mem_wdata_b;
  logic [3:0]  mem_be_b;

  logic [31:0] hw_mem [64];
  logic [31:0] ref_mem [64];
  logic [31:0] rd_a, rd_b1, rd_b2, wr_word, ref_word;

  typedef struct {
    owner_t      own;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t   q_a[$];
  exp_t   q_b[$];
  exp_t   tmp_q[$];
  exp_t   e;
  owner_t g_own;
  logic [31:0] g_data;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1), .MAX_DATA_STREAK(4)) dut_a (
    .clk(clk), .rstn(rstn),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready_a), .i_rvalid(i_rvalid_a), .i_rdata(i_rdata_a),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ready(d_ready_a), .d_rvalid(d_rvalid_a), .d_rdata(d_rdata_a),
    .flush(flush), .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_be(mem_be_a), .mem_rdata(rd_a),
    .fetch_stall(fetch_stall_a), .mem_stall(mem_stall_a)
  );

  unified_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2), .MAX_DATA_STREAK(4)) dut_b (
    .clk(clk), .rstn(rstn),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready_b), .i_rvalid(i_rvalid_b), .i_rdata(i_rdata_b),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ready(d_ready_b), .d_rvalid(d_rvalid_b), .d_rdata(d_rdata_b),
    .flush(flush), .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_be(mem_be_b), .mem_rdata(rd_b2),
    .fetch_stall(fetch_stall_b), .mem_stall(mem_stall_b)
  );

  // Memory model: dut_a performs the writes, reads come back after 1 or 2 cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en_a && mem_we_a) begin
      wr_word = hw_mem[mem_addr_a[7:2]];
      for (int k = 0; k < 4; k++) begin
        if (mem_be_a[k]) wr_word[8*k +: 8] = mem_wdata_a[8*k +: 8];
      end
      hw_mem[mem_addr_a[7:2]] <= wr_word;
    end
    rd_a  <= hw_mem[mem_addr_a[7:2]];
    rd_b1 <= hw_mem[mem_addr_b[7:2]];
    rd_b2 <= rd_b1;
  end

  // Scoreboard: match valids against expectations, apply flush, record new reads.
  always @(negedge clk) begin
    if (!rstn) begin
      q_a.delete();
      q_b.delete();
    end else begin
      if (i_rvalid_a || d_rvalid_a) begin
        checks++;
        if (q_a.size() == 0) begin
          failures++;
          $display("[TB] FAIL sb_a_unexpected: got i_rvalid=%b d_rvalid=%b at cycle %0d, expected none", i_rvalid_a, d_rvalid_a, cyc);
        end else begin
          e = q_a.pop_front();
          g_own  = i_rvalid_a ? OWN_I : OWN_D;
          g_data = i_rvalid_a ? i_rdata_a : d_rdata_a;
          if ((i_rvalid_a && d_rvalid_a) || g_own !== e.own || g_data !== e.data || cyc != e.due) begin
            failures++;
            $display("[TB] FAIL sb_a_resp: got own=%0d data=%h cycle=%0d, expected own=%0d data=%h cycle=%0d", g_own, g_data, cyc, e.own, e.data, e.due);
          end
        end
      end else if (q_a.size() != 0 && q_a[0].due < cyc) begin
        checks++;
        failures++;
        $display("[TB] FAIL sb_a_missing: got no valid by cycle %0d, expected own=%0d at cycle %0d", cyc, q_a[0].own, q_a[0].due);
        void'(q_a.pop_front());
      end
      if (i_rvalid_b || d_rvalid_b) begin
        checks++;
        if (q_b.size() == 0) begin
          failures++;
          $display("[TB] FAIL sb_b_unexpected: got i_rvalid=%b d_rvalid=%b at cycle %0d, expected none", i_rvalid_b, d_rvalid_b, cyc);
        end else begin
          e = q_b.pop_front();
          g_own  = i_rvalid_b ? OWN_I : OWN_D;
          g_data = i_rvalid_b ? i_rdata_b : d_rdata_b;
          if ((i_rvalid_b && d_rvalid_b) || g_own !== e.own || g_data !== e.data || cyc != e.due) begin
            failures++;
            $display("[TB] FAIL sb_b_resp: got own=%0d data=%h cycle=%0d, expected own=%0d data=%h cycle=%0d", g_own, g_data, cyc, e.own, e.data, e.due);
          end
        end
      end else if (q_b.size() != 0 && q_b[0].due < cyc) begin
        checks++;
        failures++;
        $display("[TB] FAIL sb_b_missing: got no valid by cycle %0d, expected own=%0d at cycle %0d", cyc, q_b[0].own, q_b[0].due);
        void'(q_b.pop_front());
      end
      if (flush) begin
        tmp_q = {};
        foreach (q_a[j]) if (!(q_a[j].own == OWN_I && q_a[j].due > cyc)) tmp_q.push_back(q_a[j]);
        q_a = tmp_q;
        tmp_q = {};
        foreach (q_b[j]) if (!(q_b[j].own == OWN_I && q_b[j].due > cyc)) tmp_q.push_back(q_b[j]);
        q_b = tmp_q;
      end
      if (i_ready_a) q_a.push_back('{own: OWN_I, data: ref_mem[i_addr[7:2]], due: cyc + 1});
      if (d_ready_a && !d_we) q_a.push_back('{own: OWN_D, data: ref_mem[d_addr[7:2]], due: cyc + 1});
      if (i_ready_b) q_b.push_back('{own: OWN_I, data: ref_mem[i_addr[7:2]], due: cyc + 2});
      if (d_ready_b && !d_we) q_b.push_back('{own: OWN_D, data: ref_mem[d_addr[7:2]], due: cyc + 2});
      if (d_req && d_we) begin
        ref_word = ref_mem[d_addr[7:2]];
        for (int k = 0; k < 4; k++) begin
          if (d_be[k]) ref_word[8*k +: 8] = d_wdata[8*k +: 8];
        end
        ref_mem[d_addr[7:2]] = ref_word;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0; flush = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 8 && (q_a.size() != 0 || q_b.size() != 0); n++) step();
  endtask

  task automatic test_reset();
    clear_inputs();
    #2;
    checks++;
    if ({i_rvalid_a, d_rvalid_a, i_rvalid_b, d_rvalid_b, mem_en_a, i_ready_a, d_ready_a} !== 7'b0 || mem_addr_a !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got valids/en/ready=%b addr=%h, expected all 0", {i_rvalid_a, d_rvalid_a, i_rvalid_b, d_rvalid_b, mem_en_a, i_ready_a, d_ready_a}, mem_addr_a);
    end
    checks++;
    if (dut_a.state_q !== IDLE || dut_b.state_q !== IDLE) begin
      failures++;
      $display("[TB] FAIL reset_state: got a=%0d b=%0d, expected IDLE", dut_a.state_q, dut_b.state_q);
    end
    d_req = 1; d_addr = 32'h44;
    #1;
    checks++;
    if ({d_ready_a, mem_en_a} !== 2'b11 || mem_addr_a !== 32'h44) begin
      failures++;
      $display("[TB] FAIL reset_comb_grant: got ready/en=%b addr=%h, expected 11 addr=00000044", {d_ready_a, mem_en_a}, mem_addr_a);
    end
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1;
    step();
  endtask

  task automatic test_contention();
    logic [5:0] d_pat = 6'b101111;
    logic       ed;
    i_req = 1; i_addr = 32'h20; d_req = 1; d_we = 0; d_addr = 32'h40;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      ed = d_pat[k];
      checks++;
      if ({d_ready_a, d_ready_b, i_ready_a, fetch_stall_a, mem_stall_a} !== {ed, ed, ~ed, ed, ~ed}) begin
        failures++;
        $display("[TB] FAIL contention_grant[%0d]: got d_rdy/d_rdy_b/i_rdy/fstall/mstall=%b, expected %b", k, {d_ready_a, d_ready_b, i_ready_a, fetch_stall_a, mem_stall_a}, {ed, ed, ~ed, ed, ~ed});
      end
      checks++;
      if (mem_addr_a !== (ed ? 32'h40 : 32'h20)) begin
        failures++;
        $display("[TB] FAIL contention_addr[%0d]: got %h, expected %h", k, mem_addr_a, ed ? 32'h40 : 32'h20);
      end
      step();
    end
    clear_inputs();
    drain();
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      failures++;
      $display("[TB] FAIL contention_drain: got %0d/%0d pending, expected 0", q_a.size(), q_b.size());
    end
  endtask

  task automatic test_single_fetch();
    i_req = 1; i_addr = 32'h10;
    @(negedge clk);
    checks++;
    if ({i_ready_a, mem_en_a, mem_we_a, mem_be_a} !== 7'b1101111 || mem_addr_a !== 32'h10) begin
      failures++;
      $display("[TB] FAIL fetch_issue: got rdy/en/we/be=%b addr=%h, expected 1101111 addr=00000010", {i_ready_a, mem_en_a, mem_we_a, mem_be_a}, mem_addr_a);
    end
    step();
    clear_inputs();
    @(negedge clk);
    checks++;
    if ({i_rvalid_a, d_rvalid_a} !== 2'b10 || i_rdata_a !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL fetch_resp: got iv/dv=%b data=%h, expected 10 data=deadbeef", {i_rvalid_a, d_rvalid_a}, i_rdata_a);
    end
    checks++;
    if ({mem_en_a, mem_we_a, mem_be_a} !== 6'b0 || mem_addr_a !== 32'h0 || mem_wdata_a !== 32'h0) begin
      failures++;
      $display("[TB] FAIL idle_zero: got en/we/be=%b addr=%h wdata=%h, expected all 0", {mem_en_a, mem_we_a, mem_be_a}, mem_addr_a, mem_wdata_a);
    end
    step();
    drain();
  endtask

  task automatic test_interleaved();
    logic [1:0]  ev;
    logic [31:0] ed;
    for (int k = 0; k < 7; k++) begin
      clear_inputs();
      if (k == 0) begin i_req = 1; i_addr = 32'h20; end
      if (k == 1) begin d_req = 1; d_addr = 32'h24; end
      if (k == 2) begin i_req = 1; i_addr = 32'h28; end
      @(negedge clk);
      ev = (k == 2 || k == 4) ? 2'b10 : (k == 3) ? 2'b01 : 2'b00;
      ed = (k == 2) ? 32'h11112222 : (k == 3) ? 32'h33334444 : 32'h55556666;
      checks++;
      if ({i_rvalid_b, d_rvalid_b} !== ev || (ev[1] && i_rdata_b !== ed) || (ev[0] && d_rdata_b !== ed)) begin
        failures++;
        $display("[TB] FAIL interleave[%0d]: got iv/dv=%b data=%h, expected %b data=%h", k, {i_rvalid_b, d_rvalid_b}, i_rdata_b, ev, ed);
      end
      if (k == 4) begin
        checks++;
        if (dut_b.state_q !== DRAIN) begin
          failures++;
          $display("[TB] FAIL interleave_drain_state: got %0d, expected DRAIN", dut_b.state_q);
        end
      end
      if (k == 6) begin
        checks++;
        if (dut_b.state_q !== IDLE) begin
          failures++;
          $display("[TB] FAIL interleave_idle_state: got %0d, expected IDLE", dut_b.state_q);
        end
      end
      step();
    end
    drain();
  endtask

  task automatic test_store_load();
    d_req = 1; d_we = 1; d_addr = 32'h30; d_wdata = 32'h000000A5; d_be = 4'b0001;
    @(negedge clk);
    checks++;
    if ({d_ready_a, mem_en_a, mem_we_a, mem_be_a} !== 7'b1110001 || mem_wdata_a !== 32'hA5 || mem_addr_a !== 32'h30) begin
      failures++;
      $display("[TB] FAIL store_issue: got rdy/en/we/be=%b wdata=%h addr=%h, expected 1110001 000000a5 00000030", {d_ready_a, mem_en_a, mem_we_a, mem_be_a}, mem_wdata_a, mem_addr_a);
    end
    step();
    clear_inputs();
    d_req = 1; d_addr = 32'h30;
    @(negedge clk);
    checks++;
    if ({d_rvalid_a, mem_we_a, d_ready_a} !== 3'b001) begin
      failures++;
      $display("[TB] FAIL store_no_rvalid: got dv/we/rdy=%b, expected 001", {d_rvalid_a, mem_we_a, d_ready_a});
    end
    step();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (d_rvalid_a !== 1'b1 || d_rdata_a !== 32'hCCCCCCA5 || d_rvalid_b !== 1'b0) begin
      failures++;
      $display("[TB] FAIL load_after_store: got dv=%b data=%h dv_b=%b, expected 1 cccccca5 0", d_rvalid_a, d_rdata_a, d_rvalid_b);
    end
    step();
    @(negedge clk);
    checks++;
    if (d_rvalid_b !== 1'b1 || d_rdata_b[7:0] !== 8'hA5) begin
      failures++;
      $display("[TB] FAIL load_after_store_b: got dv=%b byte=%h, expected 1 a5", d_rvalid_b, d_rdata_b[7:0]);
    end
    step();
    drain();
  endtask

  task automatic test_flush();
    logic [5:0]  va = 6'b001110;
    logic [5:0]  vb = 6'b010100;
    logic [31:0] da, db;
    for (int k = 0; k < 6; k++) begin
      clear_inputs();
      if (k == 0) begin i_req = 1; i_addr = 32'h20; end
      if (k == 1) begin i_req = 1; i_addr = 32'h24; end
      if (k == 2) begin i_req = 1; i_addr = 32'h28; flush = 1; end
      @(negedge clk);
      da = (k == 1) ? 32'h11112222 : (k == 2) ? 32'h33334444 : 32'h55556666;
      db = (k == 2) ? 32'h11112222 : 32'h55556666;
      checks++;
      if (i_rvalid_a !== va[k] || (va[k] && i_rdata_a !== da)) begin
        failures++;
        $display("[TB] FAIL flush_a[%0d]: got iv=%b data=%h, expected %b data=%h", k, i_rvalid_a, i_rdata_a, va[k], da);
      end
      checks++;
      if (i_rvalid_b !== vb[k] || (vb[k] && i_rdata_b !== db)) begin
        failures++;
        $display("[TB] FAIL flush_b[%0d]: got iv=%b data=%h, expected %b data=%h", k, i_rvalid_b, i_rdata_b, vb[k], db);
      end
      step();
    end
    drain();
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      failures++;
      $display("[TB] FAIL flush_drain: got %0d/%0d pending, expected 0", q_a.size(), q_b.size());
    end
  endtask

  task automatic test_reset_midflight();
    i_req = 1; i_addr = 32'h20;
    step();
    clear_inputs();
    d_req = 1; d_addr = 32'h24;
    step();
    clear_inputs();
    #1;
    checks++;
    if ({i_rvalid_b, d_rvalid_a} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL midflight_pre: got iv_b/dv_a=%b, expected 11", {i_rvalid_b, d_rvalid_a});
    end
    rstn = 0;
    #1;
    checks++;
    if ({i_rvalid_a, d_rvalid_a, i_rvalid_b, d_rvalid_b} !== 4'b0) begin
      failures++;
      $display("[TB] FAIL midflight_drop: got %b, expected 0000", {i_rvalid_a, d_rvalid_a, i_rvalid_b, d_rvalid_b});
    end
    checks++;
    if (dut_a.state_q !== IDLE || dut_b.state_q !== IDLE) begin
      failures++;
      $display("[TB] FAIL midflight_state: got a=%0d b=%0d, expected IDLE", dut_a.state_q, dut_b.state_q);
    end
    step();
    rstn = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({i_rvalid_a, d_rvalid_a, i_rvalid_b, d_rvalid_b} !== 4'b0) begin
        failures++;
        $display("[TB] FAIL midflight_after[%0d]: got %b, expected 0000", k, {i_rvalid_a, d_rvalid_a, i_rvalid_b, d_rvalid_b});
      end
      step();
    end
  endtask

  // Abort guard in case something blocks forever.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int j = 0; j < 64; j++) begin
      hw_mem[j] = 32'h0101_0101 * j;
    end
    hw_mem[4]  = 32'hDEADBEEF;
    hw_mem[8]  = 32'h11112222;
    hw_mem[9]  = 32'h33334444;
    hw_mem[10] = 32'h55556666;
    hw_mem[12] = 32'hCCCCCCCC;
    for (int j = 0; j < 64; j++) begin
      ref_mem[j] = hw_mem[j];
    end
    test_reset();
    test_contention();
    test_single_fetch();
    test_interleaved();
    test_store_load();
    test_flush();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-port synchronous memory between the fetch stage's instruction port and the memory stage's load/store port of the 5-stage pipelined RISC-V core. Each cycle it grants at most one access. By default it gives priority to the data port, with a starvation guard for fetch. It tracks in-flight reads so every read response is returned only to its owner. It also produces the `fetch_stall` and `mem_stall` signals that freeze the pipeline registers while a requester is held off.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, data word width
- `MEM_LATENCY`, 1, cycles from issued read to `mem_rdata` valid (≥1)
- `MAX_DATA_STREAK`, 4, consecutive contended data grants before fetch is forced to win (≥1)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rstn`  in  1  asynchronous active-low reset
- `i_req`  in  1  fetch read request
- `i_addr`  in  ADDR_WIDTH  fetch address
- `i_ready`  out  1  fetch request accepted this cycle
- `i_rvalid`  out  1  fetch read data valid
- `i_rdata`  out  DATA_WIDTH  fetch read data
- `d_req`  in  1  data request
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_WIDTH  data address
- `d_wdata`  in  DATA_WIDTH  store data
- `d_be`  in  DATA_WIDTH/8  store byte enables
- `d_ready`  out  1  data request accepted this cycle
- `d_rvalid`  out  1  load data valid
- `d_rdata`  out  DATA_WIDTH  load data
- `flush`  in  1  branch redirect: cancel in-flight fetch reads
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_WIDTH  memory address
- `mem_wdata`  out  DATA_WIDTH  memory write data
- `mem_be`  out  DATA_WIDTH/8  memory byte enables
- `mem_rdata`  in  DATA_WIDTH  memory read data
- `fetch_stall`  out  1  `i_req & ~i_ready`
- `mem_stall`  out  1  `d_req & ~d_ready`

## Operation
- Grant is combinational, with at most one grant per cycle:
  - only `d_req` set → data wins.
  - only `i_req` set → fetch wins.
  - both set → data wins unless `streak == MAX_DATA_STREAK`, in which case fetch wins.
- `streak` counter, width `$clog2(MAX_DATA_STREAK+1)`:
  - increments on a contended data grant;
  - clears on any fetch grant or any cycle with `i_req` low;
  - saturates at `MAX_DATA_STREAK`.
- Issue path:
  - winner's fields drive `mem_*`; `mem_en = i_ready | d_ready`.
  - fetch always issues `mem_we=0`, `mem_be` all ones.
  - when idle, `mem_*` are held at 0.
- Read tag pipe: a `MEM_LATENCY`-deep shift of owner tags (`OWN_NONE`/`OWN_I`/`OWN_D`).
  - An issued read pushes its owner; a write or idle cycle pushes `OWN_NONE`.
  - At the tail: `OWN_I` → `i_rvalid`, `OWN_D` → `d_rvalid`.
  - `i_rdata` and `d_rdata` both carry `mem_rdata`, which is meaningful only with the matching valid.
- Control FSM, states `IDLE`, `ACTIVE`, `DRAIN`:
  - `IDLE → ACTIVE` on any grant.
  - `ACTIVE → DRAIN` when there is no grant and reads are still in flight.
  - `ACTIVE`/`DRAIN → IDLE` when there is no grant and the tag pipe is all `OWN_NONE`.
  - `DRAIN → ACTIVE` on a grant.
  - The state is for observability and power gating only; the grant does not depend on it.
- `flush`:
  - every in-flight `OWN_I` tag becomes `OWN_NONE` at the clock edge, so no stale `i_rvalid` is produced.
  - a fetch granted in the same cycle as `flush` is still issued and still tagged `OWN_I` (it is the redirect target).
  - `OWN_D` tags are untouched.
- Stores complete at issue and produce no `d_rvalid`.

## Timing
- Reset (`rstn` low, asynchronous):
  - tag pipe cleared, `streak` = 0, FSM = `IDLE`.
  - `i_rvalid` = `d_rvalid` = 0. `mem_*` = 0 only when no request is present, because grant is combinational.
  - Reads in flight at reset are discarded; no valid is seen after `rstn` rises.
- Read latency: a read accepted in cycle N produces its valid in cycle N+`MEM_LATENCY`.
- Throughput: one access per cycle, reads fully pipelined.
- Stalls are combinational from `i_req`/`d_req` and the current `streak`.
- A requester holds its `req` and its fields stable until `ready` is asserted.
- `flush` and a tail `OWN_I` in the same cycle: that cycle's `i_rvalid` is still asserted. Only tags still inside the pipe are cancelled.

## Structure
- Package `mem_arb_pkg` holds:
  - `typedef enum logic [1:0] owner_t {OWN_NONE, OWN_I, OWN_D}`;
  - `typedef enum logic [1:0] arb_state_t {IDLE, ACTIVE, DRAIN}`.
- Sub-module `rd_tag_pipe`, parameterised by `MEM_LATENCY`:
  - owner shift register with the flush-clear behaviour;
  - outputs the tail tag and a `pipe_empty` flag.

## Test plan
- Contention and starvation guard: `i_req` = `d_req` = 1 held for 6 cycles, `MAX_DATA_STREAK`=4 → grants D,D,D,D,I,D; `fetch_stall` is high in cycles 0–3 and 5.
- Single fetch read: one fetch read to address 0x10, `MEM_LATENCY`=1, memory returns 0xDEADBEEF → `i_rvalid` in the next cycle with `i_rdata`=0xDEADBEEF, and `d_rvalid` stays 0.
- Interleaved reads: back-to-back fetch, load, fetch with `MEM_LATENCY`=2 → valids appear at cycles 2, 3, 4 in the order I, D, I, each with the correct data.
- Store then load: store 0xA5 with `d_be`=0001, then a load from the same address → `mem_we`/`mem_be` match the store, no `d_rvalid` for the store, and the load returns byte 0xA5.
- Flush: issue two fetches, assert `flush` one cycle later while granting a third fetch → the second fetch's valid is suppressed and the third fetch's valid is delivered.
- Reset mid-flight: assert `rstn`=0 while two reads are in flight → valids drop immediately, no valid appears after release, and the FSM is `IDLE`.
